fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register, directly upstream of decode and the load-use hazard unit.
- Generates the PC and issues single-outstanding requests to instruction memory.
- Honours pc_hold/ifid_hold from the hazard unit and redirects/flushes on a taken branch from EX.
- Presents ifid_pc/ifid_instr/ifid_valid plus decoded ifid_rs1/ifid_rs2 back to the hazard unit.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- pc_hold  input  1  freeze PC and suppress new requests.
- ifid_hold  input  1  freeze IF/ID register contents.
- branch_taken  input  1  redirect and flush, from EX.
- branch_target  input  XLEN  redirect address; bits [1:0] forced to 0.
- imem_req  output  1  request strobe, one cycle per request.
- imem_addr  output  XLEN  request address, valid while imem_req=1.
- imem_rvalid  input  1  response valid; at least 1 cycle after imem_req.
- imem_rdata  input  XLEN  instruction word, valid with imem_rvalid.
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_pc  output  XLEN  PC of the IF/ID instruction.
- ifid_instr  output  XLEN  instruction word; NOP (32'h0000_0013) when invalid.
- ifid_rs1  output  REGISTER_FILE_ADDRESS_WIDTH  ifid_instr[19:15].
- ifid_rs2  output  REGISTER_FILE_ADDRESS_WIDTH  ifid_instr[24:20].

Behaviour:
- Reset (async, any state): pc=RESET_PC, fetch_pc=0, buf=NOP, drop=0, state=S_IDLE, ifid_valid=0, ifid_pc=0, ifid_instr=NOP, imem_req=0.
- Let hold = pc_hold | ifid_hold.
- FSM states: S_IDLE (nothing outstanding), S_WAIT (one request outstanding), S_HELD (response buffered, waiting for hold to drop).
- imem_req/imem_addr are combinational: imem_req=1 and imem_addr=pc only in S_IDLE with !pc_hold and !branch_taken.
- S_IDLE: on issue, fetch_pc<=pc and go to S_WAIT. An imem_rvalid seen in S_IDLE is ignored.
- S_WAIT, imem_rvalid with drop=1: discard response, drop<=0, go to S_IDLE.
- S_WAIT, imem_rvalid with drop=0 and !hold: IF/ID<={1, fetch_pc, imem_rdata}; pc<=fetch_pc+4; go to S_IDLE.
- S_WAIT, imem_rvalid with drop=0 and hold: buf<=imem_rdata; pc<=fetch_pc+4; go to S_HELD; IF/ID unchanged.
- S_HELD, !hold: IF/ID<={1, fetch_pc, buf}; go to S_IDLE.
- IF/ID update priority, every cycle: flush > ifid_hold (retain) > load new > bubble (valid=0, instr=NOP, pc unchanged).
- Best-case throughput is one instruction per 2 cycles with 1-cycle memory latency.
- branch_taken has top priority in every state:
  - pc<={branch_target[XLEN-1:2],2'b00}; IF/ID flushed to invalid/NOP.
  - S_WAIT with no rvalid this cycle: drop<=1, stay in S_WAIT.
  - S_WAIT with rvalid this cycle: response discarded, drop unchanged, go to S_IDLE.
  - S_HELD: buffer discarded, go to S_IDLE.
  - S_IDLE: no request this cycle.
- branch_taken overrides hold.
- PC arithmetic wraps modulo 2^XLEN (32'hFFFF_FFFC+4 → 0).
- pc_hold does not block acceptance of an in-flight response; it only blocks new issue.
- No combinational path from imem_rdata to any output.

Decomposition:
- Shared package riscv_pkg:
  - REGISTER_FILE_ADDRESS_WIDTH (5).
  - XLEN.
  - NOP_INSTR (32'h0000_0013).
  - enum fetch_state_t {S_IDLE, S_WAIT, S_HELD}.
- Optional sub-module ifid_reg: the IF/ID register with hold/flush/load/bubble priority. Everything else stays inline.

Test Plan:
- Reset, memory returns rdata=0x00500093 one cycle after each req → first req addr 0x0; then ifid_valid=1, ifid_pc=0x0, ifid_rs1=0, ifid_rs2=5; second req addr 0x4.
- pc_hold=ifid_hold=1 for 3 cycles while a response arrives → IF/ID frozen, state S_HELD, no imem_req. Release → buffered instr loads with ifid_pc=fetch_pc; next req at fetch_pc+4.
- branch_taken with target 0x103 while in S_WAIT, response arrives 2 cycles later → response dropped, ifid_valid=0/NOP; next req addr 0x100.
- branch_taken in the same cycle as imem_rvalid and hold=1 → response discarded, no S_HELD, next req addr = target.
- PC at 0xFFFF_FFFC, response accepted → next req addr 0x0000_0000.
- rst asserted mid-S_WAIT, late imem_rvalid after release → ignored; first req addr RESET_PC; ifid_valid stays 0 until that response.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV32 front end: widths, the canonical NOP
// and the fetch FSM state encoding.
package riscv_pkg;

  localparam int unsigned XLEN                        = 32;
  localparam int unsigned REGISTER_FILE_ADDRESS_WIDTH = 5;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HELD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Update priority is flush > hold (retain) > load > bubble;
// a bubble clears valid and the instruction but keeps the last PC.
module ifid_reg #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);
  import riscv_pkg::*;

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= XLEN'(NOP_INSTR);
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= XLEN'(NOP_INSTR);
    end else if (!hold_i) begin
      if (load_i) begin
        valid_q <= 1'b1;
        pc_q    <= pc_i;
        instr_q <= instr_i;
      end else begin
        valid_q <= 1'b0;
        instr_q <= XLEN'(NOP_INSTR);
      end
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generation, single-outstanding imem requests, response
// buffering under hazard holds, and branch redirect/flush feeding the IF/ID register.
module fetch_stage #(
  parameter int unsigned          XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]      RESET_PC = '0
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              pc_hold,
  input  logic                                              ifid_hold,
  input  logic                                              branch_taken,
  input  logic [XLEN-1:0]                                   branch_target,
  output logic                                              imem_req,
  output logic [XLEN-1:0]                                   imem_addr,
  input  logic                                              imem_rvalid,
  input  logic [XLEN-1:0]                                   imem_rdata,
  output logic                                              ifid_valid,
  output logic [XLEN-1:0]                                   ifid_pc,
  output logic [XLEN-1:0]                                   ifid_instr,
  output logic [riscv_pkg::REGISTER_FILE_ADDRESS_WIDTH-1:0] ifid_rs1,
  output logic [riscv_pkg::REGISTER_FILE_ADDRESS_WIDTH-1:0] ifid_rs2
);
  import riscv_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic            drop_q, drop_d;

  logic            hold;
  logic            load;
  logic [XLEN-1:0] load_instr;
  logic [XLEN-1:0] target_aligned;

  assign hold           = pc_hold | ifid_hold;
  assign target_aligned = branch_target & ~XLEN'(3);

  // Issue is gated by reset too so the strobe is quiet while rst is asserted.
  assign imem_req  = (state_q == S_IDLE) && !pc_hold && !branch_taken && !rst;
  assign imem_addr = imem_req ? pc_q : '0;

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    buf_d      = buf_q;
    drop_d     = drop_q;
    load       = 1'b0;
    load_instr = buf_q;

    if (branch_taken) begin
      pc_d = target_aligned;
      unique case (state_q)
        S_WAIT: begin
          if (imem_rvalid) state_d = S_IDLE;
          else             drop_d  = 1'b1;
        end
        S_HELD:  state_d = S_IDLE;
        default: ;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!pc_hold) begin
            fetch_pc_d = pc_q;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              pc_d = fetch_pc_q + XLEN'(4);
              if (!hold) begin
                load       = 1'b1;
                load_instr = imem_rdata;
                state_d    = S_IDLE;
              end else begin
                buf_d   = imem_rdata;
                state_d = S_HELD;
              end
            end
          end
        end
        S_HELD: begin
          if (!hold) begin
            load    = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      buf_q      <= XLEN'(NOP_INSTR);
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      buf_q      <= buf_d;
      drop_q     <= drop_d;
    end
  end

  ifid_reg #(.XLEN(XLEN)) u_ifid_reg (
    .clk     (clk),
    .rst     (rst),
    .flush_i (branch_taken),
    .hold_i  (ifid_hold),
    .load_i  (load),
    .pc_i    (fetch_pc_q),
    .instr_i (load_instr),
    .valid_o (ifid_valid),
    .pc_o    (ifid_pc),
    .instr_o (ifid_instr)
  );

  // Register indices come from the registered word, never from imem_rdata.
  assign ifid_rs1 = ifid_instr[19:15];
  assign ifid_rs2 = ifid_instr[24:20];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, back-to-back fetch, hold buffering,
// branch drop/discard, PC wrap and reset during an outstanding request.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] INSTR_A = 32'h0050_0093; // addi x1,x0,5 : rs1=0 rs2=5
  localparam logic [31:0] INSTR_B = 32'h0020_81B3; // add x3,x1,x2 : rs1=1 rs2=2

  logic        clk;
  logic        rst;
  logic        pc_hold;
  logic        ifid_hold;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;

  int errors = 0;
  int checks = 0;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_hold       (pc_hold),
    .ifid_hold     (ifid_hold),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .ifid_valid    (ifid_valid),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    pc_hold       = 1'b0;
    ifid_hold     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    imem_rvalid   = 1'b0;
    imem_rdata    = '0;
    #2;
    check("rst_req",   32'(imem_req),   32'd0);
    check("rst_valid", 32'(ifid_valid), 32'd0);
    check("rst_pc",    ifid_pc,         32'h0);
    check("rst_instr", ifid_instr,      NOP_INSTR);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("first_req",  32'(imem_req), 32'd1);
    check("first_addr", imem_addr,     32'h0);

    // Basic fetch, 1-cycle memory latency.
    tick();
    imem_rvalid = 1'b1; imem_rdata = INSTR_A;
    #1;
    check("wait_no_req", 32'(imem_req), 32'd0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("a_valid", 32'(ifid_valid), 32'd1);
    check("a_pc",    ifid_pc,         32'h0);
    check("a_instr", ifid_instr,      INSTR_A);
    check("a_rs1",   32'(ifid_rs1),   32'd0);
    check("a_rs2",   32'(ifid_rs2),   32'd5);
    check("second_req",  32'(imem_req), 32'd1);
    check("second_addr", imem_addr,     32'h4);

    // ifid_hold alone still lets the request issue; IF/ID keeps A.
    ifid_hold = 1'b1;
    #1;
    check("ifid_hold_req", 32'(imem_req), 32'd1);
    tick();
    pc_hold = 1'b1; imem_rvalid = 1'b1; imem_rdata = INSTR_B;
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("held_state", 32'(dut.state_q), 32'(S_HELD));
    check("held_req",   32'(imem_req),    32'd0);
    check("held_valid", 32'(ifid_valid),  32'd1);
    check("held_instr", ifid_instr,       INSTR_A);
    tick();
    tick();
    check("held3_pc",  ifid_pc,        32'h0);
    check("held3_req", 32'(imem_req),  32'd0);
    pc_hold = 1'b0; ifid_hold = 1'b0;
    tick();
    check("rel_valid", 32'(ifid_valid), 32'd1);
    check("rel_pc",    ifid_pc,         32'h4);
    check("rel_instr", ifid_instr,      INSTR_B);
    check("rel_rs1",   32'(ifid_rs1),   32'd1);
    check("rel_rs2",   32'(ifid_rs2),   32'd2);
    check("rel_addr",  imem_addr,       32'h8);

    // Branch while waiting; response two cycles later is dropped.
    tick();
    check("bubble_valid", 32'(ifid_valid), 32'd0);
    check("bubble_instr", ifid_instr,      NOP_INSTR);
    branch_taken = 1'b1; branch_target = 32'h0000_0103;
    #1;
    check("br_wait_req", 32'(imem_req), 32'd0);
    tick();
    branch_taken = 1'b0;
    #1;
    check("drop_wait_req", 32'(imem_req), 32'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = INSTR_A;
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("drop_valid", 32'(ifid_valid), 32'd0);
    check("drop_instr", ifid_instr,      NOP_INSTR);
    check("drop_req",   32'(imem_req),   32'd1);
    check("drop_addr",  imem_addr,       32'h100);

    // Branch coincident with rvalid under hold: discard, no S_HELD.
    tick();
    imem_rvalid = 1'b1; imem_rdata = INSTR_B;
    pc_hold = 1'b1; ifid_hold = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h0000_0200;
    tick();
    imem_rvalid = 1'b0; pc_hold = 1'b0; ifid_hold = 1'b0; branch_taken = 1'b0;
    #1;
    check("coinc_state", 32'(dut.state_q), 32'(S_IDLE));
    check("coinc_valid", 32'(ifid_valid),  32'd0);
    check("coinc_addr",  imem_addr,        32'h200);
    tick();
    imem_rvalid = 1'b1; imem_rdata = INSTR_A;
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("tgt_valid", 32'(ifid_valid), 32'd1);
    check("tgt_pc",    ifid_pc,         32'h200);
    check("tgt_next",  imem_addr,       32'h204);

    // Redirect to top of address space (low bits masked), then wrap.
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    branch_taken = 1'b0;
    #1;
    check("top_valid", 32'(ifid_valid), 32'd0);
    check("top_addr",  imem_addr,       32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b1; imem_rdata = INSTR_A;
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("wrap_pc",   ifid_pc,       32'hFFFF_FFFC);
    check("wrap_req",  32'(imem_req), 32'd1);
    check("wrap_addr", imem_addr,     32'h0);

    // Reset while a request is outstanding; late response must be ignored.
    ifid_hold = 1'b1;
    tick();
    check("pre_rst_valid", 32'(ifid_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("async_valid", 32'(ifid_valid), 32'd0);
    check("async_instr", ifid_instr,      NOP_INSTR);
    ifid_hold = 1'b0;
    tick();
    rst = 1'b0; pc_hold = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = INSTR_B;
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("late_valid", 32'(ifid_valid), 32'd0);
    check("late_state", 32'(dut.state_q), 32'(S_IDLE));
    pc_hold = 1'b0;
    #1;
    check("post_rst_req",  32'(imem_req), 32'd1);
    check("post_rst_addr", imem_addr,     32'h0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = INSTR_B;
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("post_rst_valid", 32'(ifid_valid), 32'd1);
    check("post_rst_pc",    ifid_pc,         32'h0);
    check("post_rst_instr", ifid_instr,      INSTR_B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
